dbi_tx_scheduler: RTL and testbench
===================================

# dbi_tx_scheduler

Transaction scheduler between the DBI pixel FIFO, the configuration command source and the DBI TX PHY. It shares the single PHY byte channel between two requesters:
- **Configuration byte streams**: command or parameter, with a last marker.
- **Frame transfers**: auto-generated CASET/PASET/RAMWR header followed by a fixed number of pixel bytes.

It frames each transaction with CSX and the D/CX flag, never interrupts a transaction, and delivers one byte per cycle to the PHY when it is ready.

## Interface
- `DATA_W`, 8, DBI byte width.
- `COL_MAX`, 239, last column address (16-bit) sent in CASET.
- `ROW_MAX`, 319, last row address (16-bit) sent in PASET.
- `BYTES_PER_PX`, 2, bytes per pixel.
- `CNT_W`, 18, pixel-byte counter width; must hold (COL_MAX+1)*(ROW_MAX+1)*BYTES_PER_PX.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_req_valid_i`  in  1  configuration byte available.
- `cfg_req_dcx_i`  in  1  0 = command byte, 1 = parameter byte.
- `cfg_req_data_i`  in  DATA_W  configuration byte.
- `cfg_req_last_i`  in  1  final byte of the configuration transaction.
- `cfg_req_ready_o`  out  1  configuration byte accepted when valid&ready.
- `frm_req_i`  in  1  level; a full frame is buffered in the FIFO.
- `pix_valid_i`  in  1  pixel byte available.
- `pix_data_i`  in  DATA_W  pixel byte.
- `pix_ready_o`  out  1  pixel byte accepted when valid&ready.
- `phy_valid_o`  out  1  byte to PHY valid.
- `phy_dcx_o`  out  1  D/CX for the current byte.
- `phy_data_o`  out  DATA_W  byte to PHY.
- `phy_csx_o`  out  1  chip select, active low.
- `phy_ready_i`  in  1  PHY accepts byte when valid&ready.
- `busy_o`  out  1  state != IDLE.
- `frm_done_o`  out  1  one-cycle pulse at the end of a frame.

## Operation
- **States:** IDLE, CFG, HDR, PIX, DRAIN, GAP.
- **Output slot:** a single register holding phy_valid/dcx/data. It is free when `!phy_valid_o || phy_ready_i`, so a new byte loads on the same edge the old one is accepted.
- **IDLE arbitration:** fixed priority.
  - `cfg_req_valid_i` takes priority; `cfg_req_ready_o` is 1 in IDLE while it is high.
  - Otherwise `frm_req_i` starts a frame.
  - Arbitration happens only in IDLE. An active transaction is never preempted.
- **IDLE→CFG:** load the first cfg byte. If `cfg_req_last_i` is set on that byte, go directly to DRAIN.
- **CFG:**
  - `cfg_req_ready_o` = slot free.
  - Each accepted byte is loaded with its dcx.
  - An accepted byte with `last` → DRAIN.
- **IDLE→HDR:** load header index 0. Header indices 0–10:
  - 0: `0x2A` (dcx 0).
  - 1–4: `0x00`, `0x00`, `COL_MAX[15:8]`, `COL_MAX[7:0]` (dcx 1).
  - 5: `0x2B` (dcx 0).
  - 6–9: `0x00`, `0x00`, `ROW_MAX[15:8]`, `ROW_MAX[7:0]` (dcx 1).
  - 10: `0x2C` (dcx 0).
- **HDR:** advance the index each time the slot is free. Loading index 10 → PIX, with the pixel counter cleared.
- **PIX:**
  - `pix_ready_o` = slot free.
  - Each accepted pixel byte is loaded with dcx 1 and increments the counter.
  - Accepting byte number FRAME_BYTES-1 → DRAIN.
- **DRAIN:** no new loads. When the slot is accepted, go to GAP. `frm_done_o` pulses in the GAP cycle if the transaction was a frame.
- **GAP:** one cycle with `phy_csx_o` = 1, then IDLE.
- **Underflow:** if pix or cfg valid drops mid-transaction, `phy_valid_o` falls once the slot drains. CSX stays low and the state is held.
- **Cycle timing:** `cfg_req_ready_o`/`pix_ready_o` are combinational from state and slot; all other outputs are registered.

## Timing
- **Reset values:** `phy_valid_o` 0, `phy_dcx_o` 1, `phy_data_o` 0, `phy_csx_o` 1, `busy_o` 0, `frm_done_o` 0, both readies 0. State IDLE, counters 0.
- **Reset mid-operation:** all outputs revert asynchronously. A partial frame or cfg transaction is abandoned, and no `frm_done_o` is issued.
- **Start latency:** a request sampled in IDLE at edge N gives `phy_csx_o` = 0 and `phy_valid_o` = 1 with the first byte after edge N.
- **Throughput:** 1 byte/cycle with `phy_ready_i` held high.
- **Frame length:** 11 + FRAME_BYTES accepted bytes, then 1 GAP cycle.
- **Stability:** `phy_data_o`/`phy_dcx_o` are stable while `phy_valid_o` && `!phy_ready_i`.
- **CSX framing:** `phy_csx_o` is low from the first-byte cycle through the cycle the last byte is accepted, high in GAP and IDLE.
- **Simultaneous requests:** cfg and frame requests in the same IDLE cycle → cfg wins; the frame starts after cfg DRAIN+GAP if `frm_req_i` is still high.
- **Counter wrap:** none; the counter is cleared on HDR exit.

## Test plan
- **Reset:** assert `rst` mid-PIX → all outputs at reset values immediately, state IDLE, no `frm_done_o`.
- **Config transaction:** `0x11` dcx 0, then `0x3A` dcx 0, `0x55` dcx 1 last, `phy_ready_i` = 1 → three consecutive PHY bytes with matching dcx, CSX low for 3 cycles, 1 GAP cycle.
- **Full frame:** `frm_req_i` = 1, pixels always valid, `COL_MAX` = 3, `ROW_MAX` = 1, `BYTES_PER_PX` = 2 → header `2A 00 00 00 03 2B 00 00 00 01 2C`, 16 pixel bytes in order, `frm_done_o` a single pulse, CSX low for exactly 27 cycles.
- **Backpressure:** random `phy_ready_i` (50%) during a frame → no byte lost, duplicated or changed while stalled, correct total count.
- **Arbitration:** cfg valid and `frm_req_i` rise in the same cycle → cfg completes first; a cfg request arriving mid-frame waits until after GAP.
- **Underflow:** `pix_valid_i` low for 5 cycles mid-PIX → `phy_valid_o` low, CSX stays low, the frame resumes and completes with the correct byte count.

Source files
------------

// File: rtl/dbi_tx_scheduler_if.sv
// Handshake bundle between the DBI TX scheduler, its requesters (cfg source,
// pixel FIFO) and the TX PHY. The scheduler uses the slave view.
interface dbi_tx_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              cfg_req_valid_i;
  logic              cfg_req_dcx_i;
  logic [DATA_W-1:0] cfg_req_data_i;
  logic              cfg_req_last_i;
  logic              cfg_req_ready_o;
  logic              frm_req_i;
  logic              pix_valid_i;
  logic [DATA_W-1:0] pix_data_i;
  logic              pix_ready_o;
  logic              phy_valid_o;
  logic              phy_dcx_o;
  logic [DATA_W-1:0] phy_data_o;
  logic              phy_csx_o;
  logic              phy_ready_i;
  logic              busy_o;
  logic              frm_done_o;

  modport master (
    output cfg_req_valid_i, cfg_req_dcx_i, cfg_req_data_i, cfg_req_last_i,
    output frm_req_i, pix_valid_i, pix_data_i, phy_ready_i,
    input  cfg_req_ready_o, pix_ready_o, phy_valid_o, phy_dcx_o,
    input  phy_data_o, phy_csx_o, busy_o, frm_done_o
  );

  modport slave (
    input  cfg_req_valid_i, cfg_req_dcx_i, cfg_req_data_i, cfg_req_last_i,
    input  frm_req_i, pix_valid_i, pix_data_i, phy_ready_i,
    output cfg_req_ready_o, pix_ready_o, phy_valid_o, phy_dcx_o,
    output phy_data_o, phy_csx_o, busy_o, frm_done_o
  );
endinterface

// File: rtl/dbi_tx_scheduler.sv
// Shares the DBI TX PHY byte channel between config byte streams and frame
// transfers (CASET/PASET/RAMWR header + pixels), framing each with CSX/DCX.
module dbi_tx_scheduler #(
  parameter int DATA_W       = 8,
  parameter int COL_MAX      = 239,
  parameter int ROW_MAX      = 319,
  parameter int BYTES_PER_PX = 2,
  parameter int CNT_W        = 18
) (
  input logic                clk,
  input logic                rst,
  dbi_tx_scheduler_if.slave  bus
);

  localparam int               FRAME_BYTES = (COL_MAX + 1) * (ROW_MAX + 1) * BYTES_PER_PX;
  localparam logic [CNT_W-1:0] LAST_PIX    = CNT_W'(FRAME_BYTES - 1);
  localparam logic [15:0]      COL_A       = 16'(COL_MAX);
  localparam logic [15:0]      ROW_A       = 16'(ROW_MAX);
  localparam logic [3:0]       HDR_LAST    = 4'd10;

  typedef enum logic [2:0] {IDLE, CFG, HDR, PIX, DRAIN, GAP} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              dcx_q, dcx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              csx_q, csx_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              frame_q, frame_d;
  logic [3:0]        hdr_q, hdr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              slot_free;
  logic              cfg_ready, pix_ready;
  logic [DATA_W:0]   hdr_word;

  // Header entry as {dcx, byte}
  function automatic logic [DATA_W:0] hdr_entry(input logic [3:0] idx);
    logic [DATA_W:0] w;
    unique case (idx)
      4'd0:    w = {1'b0, DATA_W'(8'h2A)};
      4'd3:    w = {1'b1, DATA_W'(COL_A[15:8])};
      4'd4:    w = {1'b1, DATA_W'(COL_A[7:0])};
      4'd5:    w = {1'b0, DATA_W'(8'h2B)};
      4'd8:    w = {1'b1, DATA_W'(ROW_A[15:8])};
      4'd9:    w = {1'b1, DATA_W'(ROW_A[7:0])};
      4'd10:   w = {1'b0, DATA_W'(8'h2C)};
      default: w = {1'b1, {DATA_W{1'b0}}};
    endcase
    return w;
  endfunction

  assign slot_free = !valid_q || bus.phy_ready_i;
  assign hdr_word  = hdr_entry(hdr_q);

  always_comb begin
    state_d   = state_q;
    valid_d   = slot_free ? 1'b0 : valid_q;
    dcx_d     = dcx_q;
    data_d    = data_q;
    csx_d     = csx_q;
    done_d    = 1'b0;
    frame_d   = frame_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    cfg_ready = 1'b0;
    pix_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        csx_d = 1'b1;
        if (bus.cfg_req_valid_i) begin
          // Slot is always empty in IDLE, so the first cfg byte loads directly
          cfg_ready = 1'b1;
          valid_d   = 1'b1;
          dcx_d     = bus.cfg_req_dcx_i;
          data_d    = bus.cfg_req_data_i;
          csx_d     = 1'b0;
          frame_d   = 1'b0;
          state_d   = bus.cfg_req_last_i ? DRAIN : CFG;
        end else if (bus.frm_req_i) begin
          valid_d = 1'b1;
          {dcx_d, data_d} = hdr_entry(4'd0);
          hdr_d   = 4'd1;
          csx_d   = 1'b0;
          frame_d = 1'b1;
          state_d = HDR;
        end
      end
      CFG: begin
        cfg_ready = slot_free;
        if (slot_free && bus.cfg_req_valid_i) begin
          valid_d = 1'b1;
          dcx_d   = bus.cfg_req_dcx_i;
          data_d  = bus.cfg_req_data_i;
          if (bus.cfg_req_last_i) state_d = DRAIN;
        end
      end
      HDR: begin
        if (slot_free) begin
          valid_d = 1'b1;
          {dcx_d, data_d} = hdr_word;
          hdr_d = hdr_q + 4'd1;
          if (hdr_q == HDR_LAST) begin
            hdr_d   = '0;
            cnt_d   = '0;
            state_d = PIX;
          end
        end
      end
      PIX: begin
        pix_ready = slot_free;
        if (slot_free && bus.pix_valid_i) begin
          valid_d = 1'b1;
          dcx_d   = 1'b1;
          data_d  = bus.pix_data_i;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_PIX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (slot_free) begin
          csx_d   = 1'b1;
          done_d  = frame_q;
          state_d = GAP;
        end
      end
      GAP: begin
        frame_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      dcx_q   <= 1'b1;
      data_q  <= '0;
      csx_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      frame_q <= 1'b0;
      hdr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dcx_q   <= dcx_d;
      data_q  <= data_d;
      csx_q   <= csx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      frame_q <= frame_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cfg_req_ready_o = cfg_ready;
  assign bus.pix_ready_o     = pix_ready;
  assign bus.phy_valid_o     = valid_q;
  assign bus.phy_dcx_o       = dcx_q;
  assign bus.phy_data_o      = data_q;
  assign bus.phy_csx_o       = csx_q;
  assign bus.busy_o          = busy_q;
  assign bus.frm_done_o      = done_q;

endmodule

// File: tb/tb_dbi_tx_scheduler.sv
// Directed bench for dbi_tx_scheduler with a small 4x2 frame (16 pixel bytes).
module tb_dbi_tx_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbi_tx_scheduler_if #(.DATA_W(8)) bus ();

  dbi_tx_scheduler #(
    .DATA_W(8), .COL_MAX(3), .ROW_MAX(1), .BYTES_PER_PX(2), .CNT_W(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0]  hdr_exp [11];
  logic [9:0]  cfg_q [$];
  logic [8:0]  mon_q [$];
  int          csx_low, starve, done_cnt, stall_err;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_word = '0;
  int          pix_idx = 0;
  logic [7:0]  pix_base = '0;
  bit          rand_ready = 0;

  always @(negedge clk) begin
    if (bus.phy_valid_o && bus.phy_ready_i) mon_q.push_back({bus.phy_dcx_o, bus.phy_data_o});
    if (!bus.phy_csx_o) csx_low++;
    if (!bus.phy_csx_o && !bus.phy_valid_o) starve++;
    if (bus.frm_done_o) done_cnt++;
    if (prev_stall && (!bus.phy_valid_o || {bus.phy_dcx_o, bus.phy_data_o} != prev_word)) stall_err++;
    prev_stall = bus.phy_valid_o && !bus.phy_ready_i;
    prev_word  = {bus.phy_dcx_o, bus.phy_data_o};
  end

  function automatic logic [8:0] frame_exp(input int i, input logic [7:0] base);
    if (i < 11) return hdr_exp[i];
    return {1'b1, 8'(int'(base) + i - 11)};
  endfunction

  task automatic drive_cfg();
    if (cfg_q.size() > 0) begin
      {bus.cfg_req_dcx_i, bus.cfg_req_last_i, bus.cfg_req_data_i} = cfg_q[0];
      bus.cfg_req_valid_i = 1'b1;
    end else begin
      bus.cfg_req_valid_i = 1'b0;
    end
  endtask

  // One clock: sample handshakes mid-cycle, update sources just after the edge
  task automatic tick();
    logic tp, tc;
    @(negedge clk);
    tp = bus.pix_valid_i && bus.pix_ready_o;
    tc = bus.cfg_req_valid_i && bus.cfg_req_ready_o;
    @(posedge clk);
    #1;
    if (tp) begin
      pix_idx++;
      bus.pix_data_i = 8'(int'(pix_base) + pix_idx);
    end
    if (tc) void'(cfg_q.pop_front());
    drive_cfg();
    if (rand_ready) bus.phy_ready_i = 1'($urandom_range(0, 1));
    if (bus.frm_req_i && bus.phy_valid_o && !bus.phy_dcx_o && bus.phy_data_o == 8'h2A)
      bus.frm_req_i = 1'b0;
  endtask

  task automatic clear_mon();
    mon_q.delete();
    csx_low = 0; starve = 0; done_cnt = 0; stall_err = 0;
  endtask

  task automatic start_frame(input logic [7:0] base);
    pix_idx = 0;
    pix_base = base;
    bus.pix_data_i = base;
    bus.pix_valid_i = 1'b1;
    bus.frm_req_i = 1'b1;
  endtask

  task automatic run_until_idle(input int max, output bit ok);
    ok = 0;
    for (int n = 0; n < max; n++) begin
      if (!bus.busy_o && cfg_q.size() == 0 && !bus.frm_req_i) begin
        ok = 1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.phy_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.phy_valid_o); end
    total++; if (bus.phy_dcx_o !== 1'b1) begin bad++; $display("FAIL rst_dcx got=%b exp=1", bus.phy_dcx_o); end
    total++; if (bus.phy_data_o !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.phy_data_o); end
    total++; if (bus.phy_csx_o !== 1'b1) begin bad++; $display("FAIL rst_csx got=%b exp=1", bus.phy_csx_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
    total++; if (bus.frm_done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.frm_done_o); end
    total++; if ({bus.cfg_req_ready_o, bus.pix_ready_o} !== 2'b00) begin bad++; $display("FAIL rst_readies got=%b exp=00", {bus.cfg_req_ready_o, bus.pix_ready_o}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_config();
    bit ok;
    logic [8:0] exp [3];
    exp[0] = 9'h011; exp[1] = 9'h03A; exp[2] = 9'h155;
    clear_mon();
    cfg_q.push_back({1'b0, 1'b0, 8'h11});
    cfg_q.push_back({1'b0, 1'b0, 8'h3A});
    cfg_q.push_back({1'b1, 1'b1, 8'h55});
    drive_cfg();
    tick();
    total++;
    if ({bus.phy_valid_o, bus.phy_csx_o, bus.phy_dcx_o, bus.phy_data_o} !== {3'b100, 8'h11}) begin
      bad++; $display("FAIL cfg_start got=%b_%h exp=100_11",
        {bus.phy_valid_o, bus.phy_csx_o, bus.phy_dcx_o}, bus.phy_data_o);
    end
    run_until_idle(50, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL cfg_timeout got=%b exp=1", ok); end
    total++; if (mon_q.size() !== 3) begin bad++; $display("FAIL cfg_count got=%0d exp=3", mon_q.size()); end
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      total++; if (mon_q[i] !== exp[i]) begin bad++; $display("FAIL cfg_byte%0d got=%h exp=%h", i, mon_q[i], exp[i]); end
    end
    total++; if (csx_low !== 3) begin bad++; $display("FAIL cfg_csx_low got=%0d exp=3", csx_low); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL cfg_no_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_full_frame();
    bit ok;
    clear_mon();
    start_frame(8'hA0);
    run_until_idle(100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL frame_timeout got=%b exp=1", ok); end
    total++; if (mon_q.size() !== 27) begin bad++; $display("FAIL frame_count got=%0d exp=27", mon_q.size()); end
    for (int i = 0; i < 27 && i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i] !== frame_exp(i, 8'hA0)) begin
        bad++; $display("FAIL frame_byte%0d got=%h exp=%h", i, mon_q[i], frame_exp(i, 8'hA0));
      end
    end
    total++; if (csx_low !== 27) begin bad++; $display("FAIL frame_csx_low got=%0d exp=27", csx_low); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL frame_done got=%0d exp=1", done_cnt); end
    total++; if (starve !== 0) begin bad++; $display("FAIL frame_no_starve got=%0d exp=0", starve); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_mon();
    rand_ready = 1;
    start_frame(8'hC0);
    run_until_idle(400, ok);
    rand_ready = 0;
    bus.phy_ready_i = 1'b1;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b exp=1", ok); end
    total++; if (mon_q.size() !== 27) begin bad++; $display("FAIL bp_count got=%0d exp=27", mon_q.size()); end
    for (int i = 0; i < 27 && i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i] !== frame_exp(i, 8'hC0)) begin
        bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, mon_q[i], frame_exp(i, 8'hC0));
      end
    end
    total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_arbitration();
    bit ok = 0;
    bit injected = 0;
    logic [8:0] exp;
    clear_mon();
    cfg_q.push_back({1'b0, 1'b0, 8'hC1});
    cfg_q.push_back({1'b1, 1'b1, 8'hC2});
    drive_cfg();
    start_frame(8'h80);
    for (int n = 0; n < 200; n++) begin
      if (!bus.busy_o && cfg_q.size() == 0 && !bus.frm_req_i) begin ok = 1; break; end
      if (!injected && mon_q.size() >= 15) begin
        injected = 1;
        cfg_q.push_back({1'b0, 1'b1, 8'hD5});
        drive_cfg();
        tick();
        total++; if (bus.cfg_req_ready_o !== 1'b0) begin bad++; $display("FAIL arb_cfg_held got=%b exp=0", bus.cfg_req_ready_o); end
      end else begin
        tick();
      end
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL arb_timeout got=%b exp=1", ok); end
    total++; if (mon_q.size() !== 30) begin bad++; $display("FAIL arb_count got=%0d exp=30", mon_q.size()); end
    for (int i = 0; i < 30 && i < mon_q.size(); i++) begin
      if (i == 0) exp = 9'h0C1;
      else if (i == 1) exp = 9'h1C2;
      else if (i == 29) exp = 9'h0D5;
      else exp = frame_exp(i - 2, 8'h80);
      total++; if (mon_q[i] !== exp) begin bad++; $display("FAIL arb_byte%0d got=%h exp=%h", i, mon_q[i], exp); end
    end
    total++; if (csx_low !== 30) begin bad++; $display("FAIL arb_csx_low got=%0d exp=30", csx_low); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL arb_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_underflow();
    bit ok = 0;
    bit held = 0;
    clear_mon();
    start_frame(8'h40);
    for (int n = 0; n < 300; n++) begin
      if (!bus.busy_o && cfg_q.size() == 0 && !bus.frm_req_i) begin ok = 1; break; end
      tick();
      if (!held && pix_idx == 5) begin
        held = 1;
        bus.pix_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          if (k == 2) begin
            total++;
            if ({bus.phy_valid_o, bus.phy_csx_o, bus.busy_o} !== 3'b001) begin
              bad++; $display("FAIL uf_hold got=%b exp=001", {bus.phy_valid_o, bus.phy_csx_o, bus.busy_o});
            end
          end
        end
        bus.pix_valid_i = 1'b1;
      end
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL uf_timeout got=%b exp=1", ok); end
    total++; if (mon_q.size() !== 27) begin bad++; $display("FAIL uf_count got=%0d exp=27", mon_q.size()); end
    for (int i = 0; i < 27 && i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i] !== frame_exp(i, 8'h40)) begin
        bad++; $display("FAIL uf_byte%0d got=%h exp=%h", i, mon_q[i], frame_exp(i, 8'h40));
      end
    end
    total++; if (starve !== 5) begin bad++; $display("FAIL uf_starve got=%0d exp=5", starve); end
    total++; if (csx_low !== 32) begin bad++; $display("FAIL uf_csx_low got=%0d exp=32", csx_low); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL uf_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_pix();
    clear_mon();
    start_frame(8'h10);
    repeat (15) tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.phy_valid_o, bus.phy_dcx_o, bus.phy_data_o, bus.phy_csx_o} !== {2'b01, 8'h00, 1'b1}) begin
      bad++; $display("FAIL mid_rst_phy got=%b_%b_%h_%b exp=0_1_00_1",
        bus.phy_valid_o, bus.phy_dcx_o, bus.phy_data_o, bus.phy_csx_o);
    end
    total++;
    if ({bus.busy_o, bus.frm_done_o, bus.pix_ready_o, bus.cfg_req_ready_o} !== 4'b0000) begin
      bad++; $display("FAIL mid_rst_ctrl got=%b exp=0000",
        {bus.busy_o, bus.frm_done_o, bus.pix_ready_o, bus.cfg_req_ready_o});
    end
    bus.frm_req_i = 1'b0;
    bus.pix_valid_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL mid_rst_no_done got=%0d exp=0", done_cnt); end
    total++;
    if ({bus.busy_o, bus.phy_csx_o, bus.phy_valid_o} !== 3'b010) begin
      bad++; $display("FAIL mid_rst_idle got=%b exp=010", {bus.busy_o, bus.phy_csx_o, bus.phy_valid_o});
    end
  endtask

  initial begin
    hdr_exp[0] = 9'h02A; hdr_exp[1] = 9'h100; hdr_exp[2] = 9'h100;
    hdr_exp[3] = 9'h100; hdr_exp[4] = 9'h103; hdr_exp[5] = 9'h02B;
    hdr_exp[6] = 9'h100; hdr_exp[7] = 9'h100; hdr_exp[8] = 9'h100;
    hdr_exp[9] = 9'h101; hdr_exp[10] = 9'h02C;
    bus.cfg_req_valid_i = 1'b0;
    bus.cfg_req_dcx_i   = 1'b0;
    bus.cfg_req_data_i  = '0;
    bus.cfg_req_last_i  = 1'b0;
    bus.frm_req_i       = 1'b0;
    bus.pix_valid_i     = 1'b0;
    bus.pix_data_i      = '0;
    bus.phy_ready_i     = 1'b1;
    test_reset();
    test_config();
    test_full_frame();
    test_backpressure();
    test_arbitration();
    test_underflow();
    test_reset_mid_pix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
